// File: rtl/usr_burst.sv
// Universal shift register with eight modes and a burst engine that repeats a
// latched shift/rotate mode for burst_len enabled cycles, with busy/done status.
module usr_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       S,
   input  logic             SINR,
   input  logic             SINL,
   input  logic [WIDTH-1:0] Din,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] Dout,
   output logic             SOUTR,
   output logic             SOUTL,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, BURST, FIN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] dout_q;
   logic [CNT_W-1:0] count_q;
   logic [2:0]       bmode_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] op_d;
   logic [WIDTH-1:0] burst_d;
   logic             start_ok;

   function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       m,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic             sr,
                                                  input logic             sl,
                                                  input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      case (m)
         3'b001:  r = {sr, q[WIDTH-1:1]};
         3'b010:  r = {q[WIDTH-2:0], sl};
         3'b011:  r = d;
         3'b100:  r = {q[0], q[WIDTH-1:1]};
         3'b101:  r = {q[WIDTH-2:0], q[WIDTH-1]};
         3'b110:  r = {q[WIDTH-1], q[WIDTH-1:1]};
         3'b111:  r = '0;
         default: r = q;
      endcase
      return r;
   endfunction

   always_comb begin
      op_d     = apply_op(S, dout_q, SINR, SINL, Din);
      // Latched burst mode is always a shift/rotate, so Din never matters here.
      burst_d  = apply_op(bmode_q, dout_q, SINR, SINL, Din);
      start_ok = start && (burst_len != '0) &&
                 (S inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         dout_q  <= '0;
         count_q <= '0;
         bmode_q <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (en) begin
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  bmode_q <= S;
                  count_q <= burst_len;
                  busy_q  <= 1'b1;
                  state_q <= BURST;
               end else begin
                  dout_q <= op_d;
               end
            end
            BURST: begin
               dout_q  <= burst_d;
               count_q <= count_q - CNT_W'(1);
               // Leave on the last shift so busy covers exactly burst_len cycles.
               if (count_q == CNT_W'(1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Dout  = dout_q;
   assign SOUTR = dout_q[0];
   assign SOUTL = dout_q[WIDTH-1];
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_usr_burst.sv
// Directed bench for usr_burst: per-cycle comparison against a burst-count model
// plus literal expectations taken from worked examples.
module tb_usr_burst;
   localparam int W  = 8;
   localparam int CW = 4;
   localparam int MASK = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b1;
   logic [2:0]    S = 3'b000;
   logic          SINR = 1'b0;
   logic          SINL = 1'b0;
   logic [W-1:0]  Din = '0;
   logic          start = 1'b0;
   logic [CW-1:0] burst_len = '0;
   logic [W-1:0]  Dout;
   logic          SOUTR, SOUTL, busy, done;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   usr_burst #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .S(S), .SINR(SINR), .SINL(SINL),
      .Din(Din), .start(start), .burst_len(burst_len),
      .Dout(Dout), .SOUTR(SOUTR), .SOUTL(SOUTL), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Model: register value, shifts remaining in the current burst, and a done flag.
   int m_q = 0;
   int m_left = 0;
   int m_mode = 0;
   bit m_fin = 1'b0;

   function automatic int model_op(input int mode, input int q, input int sr,
                                   input int sl, input int d);
      case (mode)
         1: return (q >> 1) | (sr << (W - 1));
         2: return ((q << 1) | sl) & MASK;
         3: return d;
         4: return (q >> 1) | ((q & 1) << (W - 1));
         5: return ((q << 1) | (q >> (W - 1))) & MASK;
         6: return (q >> 1) | (q & (1 << (W - 1)));
         7: return 0;
         default: return q;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q = 0; m_left = 0; m_fin = 1'b0; m_mode = 0;
      end else if (en) begin
         if (m_fin) begin
            m_fin = 1'b0;
         end else if (m_left > 0) begin
            m_q = model_op(m_mode, m_q, int'(SINR), int'(SINL), int'(Din));
            m_left = m_left - 1;
            if (m_left == 0) m_fin = 1'b1;
         end else if (start && burst_len != 0 &&
                      (S == 1 || S == 2 || S == 4 || S == 5 || S == 6)) begin
            m_mode = int'(S);
            m_left = int'(burst_len);
         end else begin
            m_q = model_op(int'(S), m_q, int'(SINR), int'(SINL), int'(Din));
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (int'(Dout) != m_q || SOUTR != m_q[0] || SOUTL != m_q[W-1] ||
             busy != (m_left > 0) || done != m_fin) begin
            errors++;
            $display("FAIL model Dout=%02h/%02h SOUTR=%b/%b SOUTL=%b/%b busy=%b/%b done=%b/%b (got/want)",
                     Dout, m_q[W-1:0], SOUTR, m_q[0], SOUTL, m_q[W-1], busy, m_left > 0, done, m_fin);
         end
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // One enabled-or-not clock with the given inputs; returns at negedge+1.
   task automatic cyc(input logic [2:0] s, input logic [W-1:0] d, input logic sr,
                      input logic sl, input logic st, input logic [CW-1:0] bl,
                      input logic e);
      S = s; Din = d; SINR = sr; SINL = sl; start = st; burst_len = bl; en = e;
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("t=%0t S=%0d Din=%02h sr=%b sl=%b start=%b len=%0d en=%b -> Dout=%02h busy=%b done=%b",
               $time, s, d, sr, sl, st, bl, e, Dout, busy, done);
   endtask

   int busy_cnt;
   int done_cnt;

   initial begin
      // 1. reset
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      cmp_en = 1'b1;
      cyc(3'b011, 8'h5A, 0, 0, 0, 0, 1);
      lit("load_5a", int'(Dout), 'h5A);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      lit("async_rst_dout", int'(Dout), 0);
      lit("async_rst_busy", int'(busy), 0);
      lit("async_rst_done", int'(done), 0);
      @(negedge clk);
      #1 rst = 1'b1;
      cyc(3'b000, 8'h00, 0, 0, 0, 0, 1);
      lit("hold_after_rst", int'(Dout), 0);

      // 2. shifts
      cyc(3'b011, 8'hA5, 0, 0, 0, 0, 1);
      lit("load_a5", int'(Dout), 'hA5);
      cyc(3'b001, 8'h00, 1, 0, 0, 0, 1);
      lit("sr", int'(Dout), 'hD2);
      cyc(3'b010, 8'h00, 0, 0, 0, 0, 1);
      lit("sl", int'(Dout), 'hA4);
      lit("soutl", int'(SOUTL), 1);
      lit("soutr", int'(SOUTR), 0);

      // 3. rotate / asr / clear / enable
      cyc(3'b011, 8'h81, 0, 0, 0, 0, 1);
      cyc(3'b100, 8'h00, 0, 0, 0, 0, 1);
      lit("ror", int'(Dout), 'hC0);
      cyc(3'b101, 8'h00, 0, 0, 0, 0, 1);
      lit("rol1", int'(Dout), 'h81);
      cyc(3'b101, 8'h00, 0, 0, 0, 0, 1);
      lit("rol2", int'(Dout), 'h03);
      cyc(3'b011, 8'h90, 0, 0, 0, 0, 1);
      cyc(3'b110, 8'h00, 0, 0, 0, 0, 1);
      lit("asr", int'(Dout), 'hC8);
      cyc(3'b111, 8'h00, 0, 0, 0, 0, 1);
      lit("clear", int'(Dout), 0);
      cyc(3'b011, 8'hFF, 0, 0, 0, 0, 0);
      lit("en_low_hold", int'(Dout), 0);

      // 4. basic burst
      cyc(3'b011, 8'h01, 0, 0, 0, 0, 1);
      cyc(3'b101, 8'h00, 0, 0, 1, 3, 1);
      lit("burst_start_hold", int'(Dout), 'h01);
      lit("burst_busy0", int'(busy), 1);
      cyc(3'b011, 8'hFF, 0, 0, 1, 3, 1);
      lit("burst_d1", int'(Dout), 'h02);
      lit("burst_busy1", int'(busy), 1);
      cyc(3'b011, 8'hFF, 0, 0, 1, 3, 1);
      lit("burst_d2", int'(Dout), 'h04);
      lit("burst_busy2", int'(busy), 1);
      cyc(3'b011, 8'hFF, 0, 0, 1, 3, 1);
      lit("burst_d3", int'(Dout), 'h08);
      lit("burst_fin_busy", int'(busy), 0);
      lit("burst_fin_done", int'(done), 1);
      cyc(3'b011, 8'hFF, 0, 0, 1, 3, 1);
      lit("after_fin_dout", int'(Dout), 'h08);
      lit("after_fin_done", int'(done), 0);
      lit("after_fin_busy", int'(busy), 0);

      // 5. stalled burst and edge cases
      cyc(3'b111, 8'h00, 0, 0, 0, 0, 1);
      cyc(3'b001, 8'h00, 1, 0, 1, 2, 1);
      lit("stall_busy0", int'(busy), 1);
      cyc(3'b000, 8'h00, 1, 0, 0, 0, 1);
      lit("stall_d1", int'(Dout), 'h80);
      cyc(3'b000, 8'h00, 1, 0, 0, 0, 0);
      lit("stall_held", int'(Dout), 'h80);
      lit("stall_busy_held", int'(busy), 1);
      cyc(3'b000, 8'h00, 1, 0, 0, 0, 1);
      lit("stall_d2", int'(Dout), 'hC0);
      lit("stall_done", int'(done), 1);
      cyc(3'b000, 8'h00, 0, 0, 0, 0, 1);
      cyc(3'b001, 8'h00, 0, 0, 1, 0, 1);
      lit("len0_op", int'(Dout), 'h60);
      lit("len0_busy", int'(busy), 0);

      cyc(3'b011, 8'h01, 0, 0, 0, 0, 1);
      cyc(3'b101, 8'h00, 0, 0, 1, 15, 1);
      busy_cnt = int'(busy);
      done_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         cyc(3'b000, 8'h00, 0, 0, 0, 0, 1);
         busy_cnt += int'(busy);
         done_cnt += int'(done);
         if (i == 14) lit("max_final", int'(Dout), 'h80);
      end
      lit("max_busy_cycles", busy_cnt, 15);
      lit("max_done_count", done_cnt, 1);

      // 6. reset mid-burst
      cyc(3'b011, 8'h01, 0, 0, 0, 0, 1);
      cyc(3'b010, 8'h00, 0, 0, 1, 5, 1);
      cyc(3'b000, 8'h00, 0, 0, 0, 0, 1);
      lit("abort_d1", int'(Dout), 'h02);
      #2 rst = 1'b0;
      #1;
      lit("abort_dout", int'(Dout), 0);
      lit("abort_busy", int'(busy), 0);
      @(negedge clk);
      #1 rst = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(3'b000, 8'h00, 0, 0, 0, 0, 1);
         done_cnt += int'(done);
      end
      lit("abort_no_done", done_cnt, 0);
      cyc(3'b011, 8'h03, 0, 0, 0, 0, 1);
      cyc(3'b100, 8'h00, 0, 0, 1, 1, 1);
      lit("restart_busy", int'(busy), 1);
      cyc(3'b000, 8'h00, 0, 0, 0, 0, 1);
      lit("restart_dout", int'(Dout), 'h81);
      lit("restart_done", int'(done), 1);
      cyc(3'b000, 8'h00, 0, 0, 0, 0, 1);
      lit("restart_idle", int'(done), 0);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
